// File: rtl/mi_arbiter_if.sv
// Bundle of every requester-side (m_*) and controller-side (s_*) signal
// around the QPI memory-interface arbiter.
//   slave  : arbiter view (consumes requester commands and controller beats,
//            drives the routed command, write data and per-requester strobes)
//   master : environment view (requesters plus the QPI memory controller)
// Requester i uses slice i of every packed per-requester vector.
interface mi_arbiter_if #(
  parameter int unsigned N = 2
);
  logic [N*22-1:0] m_addr;
  logic [N*7-1:0]  m_len;
  logic [N-1:0]    m_rw;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_ready;
  logic [N*32-1:0] m_wdata;
  logic [N-1:0]    m_wack;
  logic [N-1:0]    m_wlast;
  logic [31:0]     m_rdata;
  logic [N-1:0]    m_rstb;
  logic [N-1:0]    m_rlast;

  logic [21:0]     s_addr;
  logic [6:0]      s_len;
  logic            s_rw;
  logic            s_valid;
  logic            s_ready;
  logic [31:0]     s_wdata;
  logic            s_wack;
  logic            s_wlast;
  logic [31:0]     s_rdata;
  logic            s_rstb;
  logic            s_rlast;

  modport slave (
    input  m_addr, m_len, m_rw, m_valid, m_wdata,
    output m_ready, m_wack, m_wlast, m_rdata, m_rstb, m_rlast,
    output s_addr, s_len, s_rw, s_valid, s_wdata,
    input  s_ready, s_wack, s_wlast, s_rdata, s_rstb, s_rlast
  );

  modport master (
    output m_addr, m_len, m_rw, m_valid, m_wdata,
    input  m_ready, m_wack, m_wlast, m_rdata, m_rstb, m_rlast,
    input  s_addr, s_len, s_rw, s_valid, s_wdata,
    output s_ready, s_wack, s_wlast, s_rdata, s_rstb, s_rlast
  );
endinterface

// File: rtl/mi_arbiter.sv
// Round-robin arbiter sharing the single QPI memory-interface port among N
// requesters (2..4). One requester owns the port from command handshake to
// its last data beat; its command and write data are routed downstream and
// write acks / read strobes are returned to it alone.
// Ports:
//   clk   : clock
//   rst   : asynchronous, active-high reset
//   bus   : mi_arbiter_if.slave, all m_* requester and s_* controller signals
//   owner : index of the current or most recent grantee
//   busy  : high whenever a burst is being arbitrated in or carried out
module mi_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic          clk,
  input  logic          rst,
  mi_arbiter_if.slave   bus,
  output logic [1:0]    owner,
  output logic          busy
);
  localparam int unsigned AW = 22;
  localparam int unsigned LW = 7;
  localparam int unsigned DW = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  // last starts at N-1 so requester 0 wins the first arbitration
  localparam logic [1:0] LAST_RST = 2'(N - 1);

  logic [1:0] state;
  logic [1:0] sel;
  logic [1:0] last;
  logic       rw_q;

  logic [1:0] next_sel;
  logic       any_req;
  logic       cur_valid;
  logic       cur_rw;
  logic       cmd_hs;
  logic       burst_end;

  // Circular search starting just after the previous owner: the k-th
  // candidate is (last + k) mod N, the first valid one wins.
  always_comb begin : rr_pick
    next_sel = sel;
    any_req  = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any_req && (i == (32'(last) + k) % N) && bus.m_valid[i]) begin
          next_sel = 2'(i);
          any_req  = 1'b1;
        end
      end
    end
  end

  always_comb begin : route
    cur_valid   = 1'b0;
    cur_rw      = 1'b0;
    bus.s_addr  = '0;
    bus.s_len   = '0;
    bus.s_rw    = 1'b0;
    bus.s_wdata = '0;
    bus.m_ready = '0;
    bus.m_wack  = '0;
    bus.m_wlast = '0;
    bus.m_rstb  = '0;
    bus.m_rlast = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(sel) == i) begin
        cur_valid   = bus.m_valid[i];
        cur_rw      = bus.m_rw[i];
        bus.s_addr  = bus.m_addr[i*AW +: AW];
        bus.s_len   = bus.m_len[i*LW +: LW];
        bus.s_rw    = bus.m_rw[i];
        bus.s_wdata = bus.m_wdata[i*DW +: DW];
        if (state == CMD) begin
          bus.m_ready[i] = bus.s_ready;
        end
        // downstream beats outside DATA are dropped
        if (state == DATA) begin
          bus.m_wack[i]  = bus.s_wack;
          bus.m_wlast[i] = bus.s_wlast;
          bus.m_rstb[i]  = bus.s_rstb;
          bus.m_rlast[i] = bus.s_rlast;
        end
      end
    end
    bus.s_valid = (state == CMD) && cur_valid;
  end

  assign bus.m_rdata = bus.s_rdata;
  assign cmd_hs      = (state == CMD) && cur_valid && bus.s_ready;
  // only the direction latched at the handshake can terminate the burst
  assign burst_end   = rw_q ? (bus.s_rstb && bus.s_rlast)
                            : (bus.s_wack && bus.s_wlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      last  <= LAST_RST;
      rw_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel   <= next_sel;
            state <= CMD;
          end
        end
        CMD: begin
          if (cmd_hs) begin
            rw_q  <= cur_rw;
            state <= DATA;
          end
        end
        DATA: begin
          if (burst_end) begin
            last  <= sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner = sel;
  assign busy  = (state != IDLE);
endmodule
